// File: rtl/prog_loader.sv
// Program image loader: parses a counted, checksummed byte stream into 16-bit words
// for program memory and holds the core in reset until the image verifies.
module prog_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    StCntHi, StCntLo, StDataHi, StDataLo, StChk, StRun, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              cpu_reset_q, done_q, error_q;

  logic              xfer;
  logic [15:0]       cnt_full;
  logic [ADDR_W:0]   idx_inc;

  assign in_ready = (state_q != StRun) && (state_q != StErr);
  assign xfer     = in_valid && in_ready;
  assign cnt_full = {count_q[15:8], in_data};
  assign idx_inc  = idx_q + (ADDR_W + 1)'(1);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      StCntHi: begin
        if (xfer) begin
          count_d[15:8] = in_data;
          state_d       = StCntLo;
        end
      end
      StCntLo: begin
        if (xfer) begin
          count_d = cnt_full;
          if (cnt_full == 16'd0 || 32'(cnt_full) > DEPTH) state_d = StErr;
          else                                          state_d = StDataHi;
        end
      end
      StDataHi: begin
        if (xfer) begin
          hi_d    = in_data;
          csum_d  = csum_q ^ in_data;
          state_d = StDataLo;
        end
      end
      StDataLo: begin
        if (xfer) begin
          csum_d    = csum_q ^ in_data;
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_W-1:0];
          wr_data_d = {hi_q, in_data};
          idx_d     = idx_inc;
          // idx_inc counts the word just completed, so equality means it was word N
          state_d   = (16'(idx_inc) == count_q) ? StChk : StDataHi;
        end
      end
      StChk: begin
        if (xfer) state_d = (in_data == csum_q) ? StRun : StErr;
      end
      StRun, StErr: begin
        if (reload) begin
          state_d = StCntHi;
          idx_d   = '0;
          csum_d  = '0;
        end
      end
      default: state_d = StCntHi;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StCntHi;
      count_q     <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      idx_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= (state_d != StRun);
      done_q      <= (state_d == StRun);
      error_q     <= (state_d == StErr);
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = idx_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed vector table, hand-built corner sequences and
// randomized images checked against a stream-level reference model.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [95:0] bytes;
    int          len;
    int          gap;
    bit          exp_done;
    bit          exp_err;
    int          exp_wl;
    int          exp_nwr;
    logic [15:0] exp_last;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reload;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] obs_addr[$];
  logic [15:0]       obs_data[$];
  int                exp_addr[$];
  logic [15:0]       exp_data[$];
  bit                m_done, m_err;
  int                m_wl;
  int                last_nwr;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .reload       (reload),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_addr.push_back(wr_addr);
      obs_data.push_back(wr_data);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: decode the image directly from the stream layout.
  task automatic model(input bq_t s);
    int         cnt;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    cnt = 32'({s[0], s[1]});
    if (cnt == 0 || cnt > DEPTH) begin
      m_err = 1'b1;
      m_done = 1'b0;
      m_wl = 0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      exp_addr.push_back(i);
      exp_data.push_back({s[2 + 2 * i], s[3 + 2 * i]});
      x = x ^ s[2 + 2 * i] ^ s[3 + 2 * i];
    end
    m_wl = cnt;
    m_done = (s[2 + 2 * cnt] == x);
    m_err = !m_done;
  endtask

  // Called at a negedge; returns at the negedge after the last accepted byte.
  task automatic play(input bq_t s, input int gap, output int used);
    int i = 0;
    int cyc = 0;
    int limit = s.size() * 6 + 20;
    bit take;
    while (i < s.size() && cyc < limit) begin
      in_data = s[i];
      case (gap)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: in_valid = ($urandom_range(0, 2) != 0);
      endcase
      take = in_valid && in_ready;
      @(negedge clk);
      if (take) i++;
      cyc++;
    end
    in_valid = 1'b0;
    used = i;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload in_ready", in_ready, 1);
    chk("reload done", done, 0);
    chk("reload error", error, 0);
    chk("reload cpu_reset", cpu_reset, 1);
    chk("reload words_loaded", 32'(words_loaded), 0);
  endtask

  task automatic run_stream(input string tag, input bq_t s, input int gap);
    int used;
    int n;
    model(s);
    play(s, gap, used);
    chk({tag, " consumed"}, used, s.size());
    chk({tag, " done"}, done, 32'(m_done));
    chk({tag, " error"}, error, 32'(m_err));
    chk({tag, " cpu_reset"}, cpu_reset, 32'(!m_done));
    chk({tag, " in_ready"}, in_ready, 0);
    chk({tag, " words_loaded"}, 32'(words_loaded), m_wl);
    @(negedge clk);
    chk({tag, " write count"}, obs_data.size(), exp_data.size());
    n = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
    for (int k = 0; k < n; k++) begin
      chk({tag, " wr_addr"}, 32'(obs_addr[k]), exp_addr[k]);
      chk({tag, " wr_data"}, 32'(obs_data[k]), 32'(exp_data[k]));
    end
    last_nwr = obs_data.size();
    obs_addr.delete();
    obs_data.delete();
  endtask

  initial begin
    vec_t        tbl[7];
    bq_t         s;
    logic [95:0] tmp;
    int          used;
    int          cnt;
    int          kind;
    logic [7:0]  x;
    logic [15:0] w;

    tbl[0] = '{96'h0003_0000_8FC8_0002_45, 9, 0, 1'b1, 1'b0, 3, 3, 16'h0002};
    tbl[1] = '{96'h0003_0000_8FC8_0002_44, 9, 0, 1'b0, 1'b1, 3, 3, 16'h0002};
    tbl[2] = '{96'h0041, 2, 0, 1'b0, 1'b1, 0, 0, 16'h0000};
    tbl[3] = '{96'h0000, 2, 0, 1'b0, 1'b1, 0, 0, 16'h0000};
    tbl[4] = '{96'h0003_0000_8FC8_0002_45, 9, 1, 1'b1, 1'b0, 3, 3, 16'h0002};
    tbl[5] = '{96'h0001_ABCD_66, 5, 0, 1'b1, 1'b0, 1, 1, 16'hABCD};
    tbl[6] = '{96'h0001_ABCD_67, 5, 1, 1'b0, 1'b1, 1, 1, 16'hABCD};

    reset = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    reload = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst cpu_reset", cpu_reset, 1);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_addr", 32'(wr_addr), 0);
    chk("rst wr_data", 32'(wr_data), 0);
    chk("rst words_loaded", 32'(words_loaded), 0);
    chk("rst in_ready", in_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 7; t++) begin
      do_reload();
      tmp = tbl[t].bytes;
      s.delete();
      for (int k = 0; k < tbl[t].len; k++) s.push_back(tmp[8 * (tbl[t].len - 1 - k) +: 8]);
      run_stream($sformatf("vec%0d", t), s, tbl[t].gap);
      chk($sformatf("vec%0d tbl done", t), done, 32'(tbl[t].exp_done));
      chk($sformatf("vec%0d tbl error", t), error, 32'(tbl[t].exp_err));
      chk($sformatf("vec%0d tbl words", t), 32'(words_loaded), tbl[t].exp_wl);
      chk($sformatf("vec%0d tbl nwr", t), last_nwr, tbl[t].exp_nwr);
      if (tbl[t].exp_nwr > 0) chk($sformatf("vec%0d held wr_data", t), 32'(wr_data), 32'(tbl[t].exp_last));
    end

    // Reset in the middle of a load, then a clean load afterwards.
    do_reload();
    s = '{8'h00, 8'h02, 8'h12, 8'h34};
    play(s, 0, used);
    chk("midrst consumed", used, 4);
    #2 reset = 1'b1;
    #1;
    chk("midrst in_ready", in_ready, 1);
    chk("midrst words_loaded", 32'(words_loaded), 0);
    chk("midrst cpu_reset", cpu_reset, 1);
    chk("midrst wr_en", wr_en, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst write count", obs_data.size(), 1);
    if (obs_data.size() >= 1) begin
      chk("midrst wr_addr", 32'(obs_addr[0]), 0);
      chk("midrst wr_data", 32'(obs_data[0]), 32'h1234);
    end
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk);
    s = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h66};
    run_stream("postrst", s, 0);

    // Full-depth image.
    do_reload();
    s.delete();
    s.push_back(8'h00);
    s.push_back(8'h40);
    for (int i = 0; i < 64; i++) begin
      s.push_back(8'h00);
      s.push_back(8'(i));
    end
    s.push_back(8'h00);
    run_stream("full", s, 0);
    chk("full last addr", 32'(wr_addr), 63);
    chk("full last data", 32'(wr_data), 32'h003F);
    chk("full words_loaded", 32'(words_loaded), 64);

    // Randomized images with random gaps.
    for (int r = 0; r < 25; r++) begin
      do_reload();
      kind = $urandom_range(0, 9);
      if (kind == 0)      cnt = 0;
      else if (kind == 1) cnt = $urandom_range(DEPTH + 1, 65535);
      else                cnt = $urandom_range(1, DEPTH);
      s.delete();
      s.push_back(8'(cnt >> 8));
      s.push_back(8'(cnt));
      if (kind >= 2) begin
        x = 8'h00;
        for (int i = 0; i < cnt; i++) begin
          w = 16'($urandom);
          s.push_back(w[15:8]);
          s.push_back(w[7:0]);
          x = x ^ w[15:8] ^ w[7:0];
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        s.push_back(x);
      end
      run_stream($sformatf("rand%0d", r), s, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
